// File: rtl/ttl_sync_pkg.sv
// Shared types and defaults for the synchronous TTL clock-enable models.
// Each divider stage is carried as a level plus its single-cycle edge strobes.
package ttl_sync_pkg;

   localparam int DEF_W = 10;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } cen_strobe_t;

endpackage

// File: rtl/ttl_cen_frac_acc.sv
// Fractional-rate accumulator: adds NUM each enabled cycle, wraps at DEN and
// flags a tick on wrap. tick_now is the combinational tick, tick its registered copy.
module ttl_cen_frac_acc
   import ttl_sync_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         sync,
   input  logic [W-1:0] num,
   input  logic [W-1:0] den,
   output logic         tick_now,
   output logic         tick
);

   logic [W:0]   acc_q, acc_d;
   logic         tick_q, tick_d;
   logic [W+1:0] sum, diff;

   // One guard bit above the accumulator; an out-of-range result after an
   // illegal operand change restarts the phase instead of wrapping silently.
   always_comb begin
      sum    = {1'b0, acc_q} + {2'b00, num};
      diff   = sum - {2'b00, den};
      acc_d  = acc_q;
      tick_d = 1'b0;
      if (sync) begin
         acc_d = '0;
      end else if (en) begin
         if (sum >= {2'b00, den}) begin
            tick_d = 1'b1;
            acc_d  = diff[W+1] ? '0 : diff[W:0];
         end else begin
            acc_d  = sum[W+1] ? '0 : sum[W:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign tick_now = tick_d;
   assign tick     = tick_q;

endmodule

// File: rtl/ttl_cen_gen_sync.sv
// Pseudo-clock enable generator: fractional base toggle feeding a ripple
// chain of divide-by-two stages, each exported as level, rise and fall.
module ttl_cen_gen_sync
   import ttl_sync_pkg::*;
#(
   parameter int BLOCKS = 2,
   parameter int W      = DEF_W
) (
   input  logic              Clk,
   input  logic              RSTn,
   input  logic              En,
   input  logic              Sync,
   input  logic [W-1:0]      NUM,
   input  logic [W-1:0]      DEN,
   output logic [BLOCKS-1:0] Cen,
   output logic [BLOCKS-1:0] Rise,
   output logic [BLOCKS-1:0] Fall,
   output logic              Tick
);

   logic              tick_now;
   logic [BLOCKS-1:0] toggle;

   ttl_cen_frac_acc #(.W(W)) u_acc (
      .clk      (Clk),
      .rst_n    (RSTn),
      .en       (En),
      .sync     (Sync),
      .num      (NUM),
      .den      (DEN),
      .tick_now (tick_now),
      .tick     (Tick)
   );

   // tick_now is already gated by En and Sync, so the whole chain resolves
   // combinationally from it and every stage registers on the same edge.
   assign toggle[0] = tick_now;

   for (genvar k = 0; k < BLOCKS; k++) begin : g_stage
      cen_strobe_t stage_q, stage_d;

      always_comb begin
         stage_d      = stage_q;
         stage_d.rise = 1'b0;
         stage_d.fall = 1'b0;
         if (Sync) begin
            stage_d.level = 1'b0;
            stage_d.fall  = stage_q.level;
         end else if (toggle[k]) begin
            stage_d.level = ~stage_q.level;
            stage_d.rise  = ~stage_q.level;
            stage_d.fall  = stage_q.level;
         end
      end

      always_ff @(posedge Clk or negedge RSTn) begin
         if (!RSTn) begin
            stage_q <= '0;
         end else begin
            stage_q <= stage_d;
         end
      end

      if (k < BLOCKS - 1) begin : g_carry
         assign toggle[k+1] = toggle[k] & stage_q.level;
      end

      assign Cen[k]  = stage_q.level;
      assign Rise[k] = stage_q.rise;
      assign Fall[k] = stage_q.fall;
   end

endmodule

// File: doc/ttl_cen_gen_sync.md
Name: ttl_cen_gen_sync

Overview:
Synchronous generator of the pseudo-clock enables consumed by the ttl_*_sync edge-detecting TTL models. It derives a fractional-rate base toggle from the system clock. That toggle drives a behavioural ripple chain equivalent to cascaded J=K=1 flip-flops. Each stage is presented as a level (Cen) plus single-cycle rise and fall strobes. It sits at the top of each board-level clock tree (pixel clock, CPU phi, divider chains) and drives the Cen inputs of downstream sync TTL blocks.

Parameters:
BLOCKS, 2, number of divider stages; stage k runs at half the rate of stage k-1
W, 10, width of NUM and DEN inputs; accumulator is W+1 bits

Ports:
Clk  in  1  system clock; all state changes on posedge
RSTn  in  1  asynchronous active-low reset
En  in  1  run enable; low freezes all state
Sync  in  1  synchronous phase reset
NUM  in  W  fractional numerator
DEN  in  W  fractional denominator
Cen  out  BLOCKS  divided enable levels, stage 0 = base toggle
Rise  out  BLOCKS  one-cycle strobe in the first cycle Cen[k] reads 1
Fall  out  BLOCKS  one-cycle strobe in the first cycle Cen[k] reads 0
Tick  out  1  one-cycle strobe: accumulator overflow this cycle

Behaviour:
- Reset and initialisation:
  - Clock is Clk. Reset RSTn is asynchronous, active-low.
  - RSTn low clears immediately, without waiting for a clock: acc=0, Cen=0, Rise=0, Fall=0, Tick=0.
  - Power-up initial values are identical to the reset values.
- Priority per posedge: RSTn > Sync > En > hold.
- Accumulator, when En=1 and Sync=0:
  - s = acc + NUM, computed W+1 bits wide.
  - If s >= DEN: acc <= s - DEN and tick=1. Otherwise acc <= s and tick=0.
  - At most one tick per cycle.
  - Average tick rate = Clk * NUM / DEN.
- Operand rules:
  - Legal range: 0 <= NUM <= DEN and DEN != 0.
  - NUM=0: no ticks ever.
  - NUM=DEN: a tick every cycle.
  - Changing NUM or DEN is defined only in a cycle with Sync=1. Otherwise the result is unspecified, but the accumulator must not overflow its W+1 bits.
- Ripple chain, evaluated within one cycle and registered once:
  - Stage 0 toggles on tick.
  - Stage k (k >= 1) toggles when stage k-1 makes a 1->0 transition in the same cycle.
  - No extra latency per stage: all stages update on the same posedge.
- Strobes:
  - Registered alongside Cen. Fall[k]=1 exactly in the cycle where Cen[k] is newly 0 (previous cycle 1). Rise[k] is the equivalent for 0->1.
  - Tick is registered and coincides with the Cen[0] change.
- En=0: acc and Cen hold; Rise, Fall and Tick are 0.
- Sync=1 (takes effect regardless of En):
  - acc <= 0 and all Cen <= 0.
  - Fall[k]=1 in the following cycle for every stage that was 1, so strobes stay consistent with the levels seen by downstream last-cen detectors.
  - Rise=0 and Tick=0.
- Downstream timing: a consumer that samples Cen and detects 1->0 updates its state on the posedge that ends the first Cen-low cycle.
- Reset asserted mid-period: no strobes are generated for the forced clear. Downstream blocks share the same reset.

Decomposition:
- Shared package ttl_sync_pkg holds:
  - typedef cen_strobe_t: struct of level, rise and fall bits.
  - localparam DEF_W = 10.
- One natural sub-module, ttl_cen_frac_acc: the NUM/DEN accumulator, producing tick.
- The ripple chain and strobe registers stay in the top module as a generate loop over BLOCKS.

Test Plan:
- Reset: hold RSTn=0 mid-run with Cen=3 (BLOCKS=2) -> Cen, Rise, Fall and Tick all 0 immediately, before any Clk edge.
- NUM=1, DEN=4, BLOCKS=3, En=1 after Sync:
  - Tick every 4th cycle.
  - Cen[0] period 8, Cen[1] period 16, Cen[2] period 32, each at 50% duty.
  - Fall[0] fires once per 8 cycles; Fall[2] coincides with Fall[1] and Fall[0].
- NUM=3, DEN=8 from acc=0:
  - Tick on cycles 3, 6, 8, then repeats every 8 cycles.
  - Exactly 3 Cen[0] toggles per 8 cycles.
- NUM=DEN=5 -> Tick every cycle; Cen[0] alternates 1,0,1,0; Rise[0] and Fall[0] alternate every cycle.
- Sync asserted with Cen[0]=1, Cen[1]=1, acc=2:
  - Next cycle Cen=0, Fall[1:0]=2'b11, Rise=0, acc=0.
  - First Tick then arrives DEN/NUM cycles later.
- En=0 for 10 cycles mid-period: Cen and acc frozen, no strobes. On En=1, the tick schedule resumes exactly where it stopped; NUM=0 yields no Tick over 100 cycles.
